dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder_pkg.sv | 15 +
 rtl/dmem_responder_if.sv | 24 ++
 rtl/dmem_responder_sram.sv | 36 +++
 rtl/dmem_responder.sv | 93 +++++++++
 tb/tb_dmem_responder.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared core types and constants for the data-memory responder.
package dmem_responder_pkg;

  localparam int unsigned DMEM_MAX_LATENCY = 4;
  localparam int unsigned DMEM_DW          = 32;
  localparam int unsigned DMEM_BW          = DMEM_DW / 8;

  // One slot of the read-response pipeline.
  typedef struct packed {
    logic               vld;
    logic               err;
    logic [DMEM_DW-1:0] rdata;
  } dmem_rsp_t;

endpackage

// File: rtl/dmem_responder_if.sv
// Requester <-> responder data bus: request, grant and read response.
interface dmem_responder_if;
  import dmem_responder_pkg::*;

  logic               data_req_i;
  logic [31:0]        data_addr_i;
  logic               data_we_i;
  logic [DMEM_BW-1:0] data_be_i;
  logic [DMEM_DW-1:0] data_wdata_i;
  logic               data_gnt_o;
  logic               data_rvalid_o;
  logic [DMEM_DW-1:0] data_rdata_o;
  logic               data_err_o;

  modport master (
    output data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
    input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o
  );

  modport slave (
    input  data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
    output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o
  );
endinterface

// File: rtl/dmem_responder_sram.sv
// Single-port, byte-enabled word array with registered read data.
module dmem_sram
  import dmem_responder_pkg::*;
#(
  parameter  int unsigned DEPTH = 1024,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic               clk_i,
  input  logic               i_en,
  input  logic               i_we,
  input  logic [DMEM_BW-1:0] i_be,
  input  logic [AW-1:0]      i_addr,
  input  logic [DMEM_DW-1:0] i_wdata,
  output logic [DMEM_DW-1:0] o_rdata
);

  // Contents are deliberately not reset; they are undefined until written.
  logic [DMEM_DW-1:0] r_mem [DEPTH];
  logic [DMEM_DW-1:0] r_rdata;

  // One access per cycle: byte-masked write, or capture the addressed word.
  always_ff @(posedge clk_i) begin
    if (i_en) begin
      if (i_we) begin
        for (int b = 0; b < int'(DMEM_BW); b++) begin
          if (i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end else begin
        r_rdata <= r_mem[i_addr];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: grant, address check, fixed-latency read pipeline,
// saturating fault counter. Storage lives in dmem_sram.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  dmem_responder_if.slave  bus,
  input  logic             stall_i,
  output logic [7:0]       err_cnt_o
);

  localparam int unsigned AW    = $clog2(DEPTH_WORDS);
  localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) << 2;

  if (LATENCY < 1 || LATENCY > DMEM_MAX_LATENCY) begin : g_bad_latency
    $error("dmem_responder: LATENCY out of range 1..DMEM_MAX_LATENCY");
  end

  logic               w_gnt;
  logic               w_fault;
  logic               w_rd_gnt;
  logic [32:0]        w_off;
  logic [AW-1:0]      w_idx;
  logic [DMEM_DW-1:0] w_q;
  logic               r_vld0;
  logic               r_err0;
  logic [7:0]         r_err_cnt;
  dmem_rsp_t          w_st [LATENCY];

  // Stall is the only throttle; grant is held low while in reset.
  assign w_gnt    = bus.data_req_i & ~stall_i & rst_ni;
  assign w_rd_gnt = w_gnt & ~bus.data_we_i;

  // 33-bit offset: an address below the base borrows into bit 32, which
  // already makes it >= LIMIT, so one compare covers both range ends.
  assign w_off   = {1'b0, bus.data_addr_i} - {1'b0, ADDR_BASE};
  assign w_fault = (bus.data_addr_i[1:0] != 2'b00) | (w_off >= LIMIT);
  assign w_idx   = w_off[AW+1:2];

  dmem_sram #(.DEPTH(DEPTH_WORDS)) u_sram (
    .clk_i   (clk_i),
    .i_en    (w_gnt & ~w_fault),
    .i_we    (bus.data_we_i),
    .i_be    (bus.data_be_i),
    .i_addr  (w_idx),
    .i_wdata (bus.data_wdata_i),
    .o_rdata (w_q)
  );

  // Stage 0 control: loaded at the grant edge alongside the SRAM read.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_vld0 <= 1'b0;
      r_err0 <= 1'b0;
    end else begin
      r_vld0 <= w_rd_gnt;
      r_err0 <= w_rd_gnt & w_fault;
    end
  end

  // Data is zeroed for idle slots and faults so every later stage is clean.
  assign w_st[0] = '{vld:   r_vld0,
                     err:   r_err0,
                     rdata: (r_vld0 & ~r_err0) ? w_q : '0};

  for (genvar k = 1; k < int'(LATENCY); k++) begin : g_stage
    dmem_rsp_t r_st;
    // Free-running shift: responses leave in grant order, never stalled.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_st <= '0;
      else         r_st <= w_st[k-1];
    end
    assign w_st[k] = r_st;
  end

  // Count faulting grants (reads and writes), sticking at 8'hFF.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                                r_err_cnt <= 8'h00;
    else if (w_gnt && w_fault && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'h01;
  end

  assign bus.data_gnt_o    = w_gnt;
  assign bus.data_rvalid_o = w_st[LATENCY-1].vld;
  assign bus.data_err_o    = w_st[LATENCY-1].err;
  assign bus.data_rdata_o  = w_st[LATENCY-1].rdata;
  assign err_cnt_o         = r_err_cnt;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench: four responders (LATENCY 1..4) share one stimulus stream; a
// reference memory model pushes expected read responses, and a monitor
// matches every rvalid (data, err, arrival cycle) per instance.
module tb_dmem_responder;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          DEPTH = 16;
  localparam int          NL    = 4;

  typedef struct packed {
    int          gcyc;
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic req, we, stall;
  logic [31:0] addr, wdata;
  logic [3:0]  be;

  logic [NL-1:0]       gnt, rvalid, rerr;
  logic [NL-1:0][31:0] rdata;
  logic [NL-1:0][7:0]  ecnt;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   exp_cnt = 0;
  int   ptr [NL];
  exp_t sbq [$];
  exp_t e;
  logic [31:0] mmem [DEPTH];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NL; g++) begin : g_dut
    dmem_responder_if bus ();
    assign bus.data_req_i   = req;
    assign bus.data_addr_i  = addr;
    assign bus.data_we_i    = we;
    assign bus.data_be_i    = be;
    assign bus.data_wdata_i = wdata;
    assign gnt[g]    = bus.data_gnt_o;
    assign rvalid[g] = bus.data_rvalid_o;
    assign rerr[g]   = bus.data_err_o;
    assign rdata[g]  = bus.data_rdata_o;

    dmem_responder #(.ADDR_BASE(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(g + 1)) u_dut (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .bus       (bus.slave),
      .stall_i   (stall),
      .err_cnt_o (ecnt[g])
    );
  end

  function automatic bit is_fault(logic [31:0] a);
    longint la;
    la = longint'(a);
    return (a[1:0] != 2'b00) || (la < longint'(BASE)) || (la >= longint'(BASE) + 4 * DEPTH);
  endfunction

  // Response monitor: instance i (LATENCY i+1) must answer grant cycle g at g+i+1.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      for (int i = 0; i < NL; i++) begin
        total++;
        if (rvalid[i] === 1'b1) begin
          if (ptr[i] >= sbq.size()) begin
            bad++;
            $display("FAIL rsp_extra dut%0d cyc=%0d got data=%h err=%b, no response expected", i, cyc, rdata[i], rerr[i]);
          end else begin
            e = sbq[ptr[i]];
            ptr[i]++;
            if (e.gcyc + i + 1 != cyc || rdata[i] !== e.data || rerr[i] !== e.err) begin
              bad++;
              $display("FAIL rsp dut%0d cyc=%0d got data=%h err=%b, want cyc=%0d data=%h err=%b",
                       i, cyc, rdata[i], rerr[i], e.gcyc + i + 1, e.data, e.err);
            end
          end
        end else begin
          if (rdata[i] !== 32'h0 || rerr[i] !== 1'b0 || rvalid[i] !== 1'b0) begin
            bad++;
            $display("FAIL idle dut%0d cyc=%0d got rvalid=%b data=%h err=%b, want all 0", i, cyc, rvalid[i], rdata[i], rerr[i]);
          end else if (ptr[i] < sbq.size() && sbq[ptr[i]].gcyc + i + 1 <= cyc) begin
            bad++;
            $display("FAIL rsp_missing dut%0d cyc=%0d got no rvalid, want data=%h due cyc=%0d",
                     i, cyc, sbq[ptr[i]].data, sbq[ptr[i]].gcyc + i + 1);
            ptr[i]++;
          end
        end
      end
    end
  end

  // One bus cycle: drive, check grant and fault count, update the model.
  task automatic step(bit r, bit w, logic [31:0] a, logic [3:0] b, logic [31:0] d, bit s);
    bit g, f;
    int idx;
    req = r; we = w; addr = a; be = b; wdata = d; stall = s;
    @(negedge clk);
    g = r & ~s;
    for (int i = 0; i < NL; i++) begin
      total++;
      if (gnt[i] !== g) begin
        bad++;
        $display("FAIL gnt dut%0d cyc=%0d got %b want %b", i, cyc, gnt[i], g);
      end
      total++;
      if (ecnt[i] !== 8'(exp_cnt)) begin
        bad++;
        $display("FAIL err_cnt dut%0d cyc=%0d got %0d want %0d", i, cyc, ecnt[i], exp_cnt);
      end
    end
    if (g) begin
      f = is_fault(a);
      if (f && exp_cnt != 255) exp_cnt++;
      idx = f ? 0 : int'((a - BASE) >> 2) % DEPTH;
      if (!w) begin
        sbq.push_back('{gcyc: cyc, data: f ? 32'h0 : mmem[idx], err: f});
      end else if (!f) begin
        for (int n = 0; n < 4; n++)
          if (b[n]) mmem[idx][8*n +: 8] = d[8*n +: 8];
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(int n);
    repeat (n) step(1'b0, 1'b0, BASE, 4'h0, 32'h0, 1'b0);
  endtask

  // Reset with a request held: no grant, no response, counter cleared.
  task automatic do_reset();
    rst_n = 1'b0; req = 1'b1; we = 1'b0; stall = 1'b0;
    addr = BASE; be = 4'hF; wdata = 32'h0;
    sbq.delete();
    for (int i = 0; i < NL; i++) ptr[i] = 0;
    exp_cnt = 0;
    repeat (2) begin
      @(negedge clk);
      for (int i = 0; i < NL; i++) begin
        total++;
        if (gnt[i] !== 1'b0 || rvalid[i] !== 1'b0 || rerr[i] !== 1'b0 || ecnt[i] !== 8'h00) begin
          bad++;
          $display("FAIL reset dut%0d got gnt=%b rvalid=%b err=%b cnt=%0d want all 0",
                   i, gnt[i], rvalid[i], rerr[i], ecnt[i]);
        end
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b1; req = 1'b0;
  endtask

  initial begin
    do_reset();

    // Fill the whole array so every later read has a defined model value.
    for (int w = 0; w < DEPTH; w++) step(1'b1, 1'b1, BASE + 32'(4 * w), 4'hF, $urandom, 1'b0);

    // Write then read the next cycle.
    step(1'b1, 1'b1, BASE + 32'h10, 4'hF, 32'hDEAD_BEEF, 1'b0);
    step(1'b1, 1'b0, BASE + 32'h10, 4'hF, 32'h0, 1'b0);

    // Byte-enable merge; read with be=0 still returns the full word.
    step(1'b1, 1'b1, BASE + 32'h20, 4'hF, 32'h1122_3344, 1'b0);
    step(1'b1, 1'b1, BASE + 32'h20, 4'b0110, 32'hAABB_CCDD, 1'b0);
    step(1'b1, 1'b0, BASE + 32'h20, 4'h0, 32'h0, 1'b0);

    // be=0 write leaves memory alone and is not a fault.
    step(1'b1, 1'b1, BASE + 32'h20, 4'h0, 32'h5555_5555, 1'b0);
    step(1'b1, 1'b0, BASE + 32'h20, 4'hF, 32'h0, 1'b0);

    // Back-to-back reads of 1, 2, 3.
    step(1'b1, 1'b1, BASE + 32'h0, 4'hF, 32'd1, 1'b0);
    step(1'b1, 1'b1, BASE + 32'h4, 4'hF, 32'd2, 1'b0);
    step(1'b1, 1'b1, BASE + 32'h8, 4'hF, 32'd3, 1'b0);
    step(1'b1, 1'b0, BASE + 32'h0, 4'hF, 32'h0, 1'b0);
    step(1'b1, 1'b0, BASE + 32'h4, 4'hF, 32'h0, 1'b0);
    step(1'b1, 1'b0, BASE + 32'h8, 4'hF, 32'h0, 1'b0);
    idle(6);

    // Faults: misaligned read, write one past the end (would alias word 0).
    do_reset();
    step(1'b1, 1'b0, BASE + 32'h2, 4'hF, 32'h0, 1'b0);
    step(1'b1, 1'b1, BASE + 32'(4 * DEPTH), 4'hF, 32'hCAFE_F00D, 1'b0);
    step(1'b1, 1'b0, BASE + 32'h0, 4'hF, 32'h0, 1'b0);
    step(1'b1, 1'b0, BASE - 32'h4, 4'hF, 32'h0, 1'b0);
    idle(6);

    // Stall for 5 cycles with the request held, then release.
    repeat (5) step(1'b1, 1'b0, BASE + 32'h8, 4'hF, 32'h0, 1'b1);
    step(1'b1, 1'b0, BASE + 32'h8, 4'hF, 32'h0, 1'b0);
    idle(6);

    // Reset one cycle after a read grant kills the in-flight response.
    step(1'b1, 1'b0, BASE + 32'h4, 4'hF, 32'h0, 1'b0);
    do_reset();
    idle(6);

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      int sel;
      logic [31:0] a;
      sel = $urandom_range(0, 9);
      if (sel < 8)       a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
      else if (sel == 8) a = BASE + 32'($urandom_range(0, 4 * DEPTH - 1));
      else if ($urandom_range(0, 1) == 0) a = BASE - 32'(4 * $urandom_range(1, 4));
      else               a = BASE + 32'(4 * DEPTH + 4 * $urandom_range(0, 3));
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, a,
           4'($urandom_range(0, 15)), $urandom, $urandom_range(0, 3) == 0);
    end
    idle(6);

    // Saturate the fault counter with back-to-back faulting reads.
    repeat (260) step(1'b1, 1'b0, BASE + 32'h1, 4'hF, 32'h0, 1'b0);
    idle(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
